pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Program-counter stage of the IF pipeline stage; directly downstream of the next-PC 4:1 mux.
- The mux selects among PC+4, branch target, jump target and register target; this block registers that value as the fetch address.
- Applies stall, halt and debug-unit run/step control to the PC update.
- Exports PC+4 back to the mux (input A), an advance strobe for the IF/ID latch, and a cycle counter for the debug unit.

Parameters:
SIZE, 32, PC width in bits
COUNT_SIZE, 32, cycle counter width in bits
RESET_PC, 0, PC value loaded on reset; must be a multiple of 4

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_reset  input  1  synchronous, active-high reset
i_enable  input  1  debug unit allows execution; level signal
i_step_mode  input  1  1 = single-step, 0 = continuous; sampled only in IDLE
i_step  input  1  step request from debug unit; may be held for several cycles
i_stall  input  1  load-use hazard from the hazard unit; hold the PC
i_halt  input  1  HALT instruction decoded in ID
i_next_pc  input  SIZE  next PC from the next-PC mux output
o_pc  output  SIZE  current fetch address (registered)
o_pc_plus4  output  SIZE  o_pc + 4, combinational, modulo 2^SIZE; feeds mux input A
o_advance  output  1  1-cycle pulse in the cycle o_pc loads i_next_pc; IF/ID latch write-enable
o_halted  output  1  1 while in HALTED
o_cycle_count  output  COUNT_SIZE  number of executed cycles

Behaviour:
- Reset (synchronous, priority over everything):
  - o_pc=RESET_PC, so o_pc_plus4=RESET_PC+4.
  - o_advance=0, o_halted=0, o_cycle_count=0.
  - State=IDLE; step edge-detect register cleared.
  - Reset mid-run or while halted returns to this same state in the next cycle.
- States:
  - IDLE: PC frozen.
    - i_enable=1 and i_step_mode=0 -> RUN.
    - i_enable=1 and i_step_mode=1 -> STEP_WAIT.
    - Leaving IDLE does not advance the PC in that cycle.
  - RUN: every cycle is an "exec cycle" (rules below).
    - i_enable=0 -> IDLE, PC held, no exec in that cycle.
  - STEP_WAIT:
    - A rising edge of i_step (i_step=1 and the previous cycle's i_step=0) makes that cycle an exec cycle.
    - A held i_step gives exactly one exec.
    - i_enable=0 -> IDLE.
  - HALTED: PC, count and outputs frozen; o_halted=1; only reset leaves this state.
- Exec cycle rules, in priority order:
  1. i_halt=1: next state HALTED, o_pc held, o_advance=0, count+1. Halt beats stall when both are asserted.
  2. i_stall=1: o_pc held, o_advance=0, count+1.
  3. Otherwise: o_pc <= {i_next_pc[SIZE-1:2], 2'b00} (low two bits forced to 0), o_advance=1, count+1.
- Non-exec cycles: o_advance=0, count unchanged.
- o_advance is a registered strobe, asserted in the same edge on which o_pc updates; latency from exec cycle to new o_pc is 1 clock.
- Wrap and saturation:
  - o_pc_plus4 wraps modulo 2^SIZE (0xFFFFFFFC -> 0x00000000).
  - o_cycle_count saturates at all-ones.
- i_step_mode changes outside IDLE are ignored until the next IDLE.

Decomposition:
- Shared pipeline package holds:
  - the state encoding (IDLE=2'b00, RUN=2'b01, STEP_WAIT=2'b10, HALTED=2'b11);
  - the PC_INCREMENT constant 4;
  - the default RESET_PC.
- One sub-module: edge_detect (registered rising-edge detector, synchronous active-high reset), used for i_step.
- FSM, PC register and counter stay in pc_unit.

Test Plan:
- Reset, then i_enable=1, step_mode=0, i_next_pc tied to o_pc_plus4 for 5 cycles -> o_pc steps 0,4,8,12,16,20; o_advance=1 on each update; count=5.
- In RUN, i_stall=1 for 2 cycles with i_next_pc=0x40 -> o_pc holds, o_advance=0, count+2; stall released -> o_pc=0x40 next cycle.
- Step mode, i_step held high for 4 cycles, then low, then high for 1 cycle -> exactly 2 PC advances; count=2.
- i_halt=1 and i_stall=1 in the same exec cycle with i_next_pc=0x80 -> HALTED, o_halted=1, o_pc unchanged; further i_step and i_enable have no effect.
- i_next_pc=0x00000013 -> o_pc=0x00000010; o_pc=0xFFFFFFFC -> o_pc_plus4=0x00000000.
- Reset asserted in HALTED, and separately mid-RUN -> next cycle o_pc=RESET_PC, count=0, o_halted=0, state IDLE.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// ----------------------------------------------------------------------------
// Module : pc_unit_pkg
// Brief  : Shared IF-stage definitions: PC FSM encoding and PC constants.
// Rev    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package pc_unit_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RUN       = 2'b01,
    STEP_WAIT = 2'b10,
    HALTED    = 2'b11
  } pc_state_t;

  localparam int unsigned PC_INCREMENT     = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/pc_unit_edge_detect.sv
// ----------------------------------------------------------------------------
// Module : pc_unit_edge_detect
// Brief  : Rising-edge detector; pulses in the cycle the input goes 0 -> 1.
// Rev    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module pc_unit_edge_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_in,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_prev <= 1'b0;
    else         r_prev <= i_in;
  end

  assign o_rise = i_in & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
// ----------------------------------------------------------------------------
// Module : pc_unit
// Brief  : Fetch PC register with run/step/halt/stall control and cycle counter.
// Rev    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int              SIZE       = 32,
  parameter int              COUNT_SIZE = 32,
  parameter logic [SIZE-1:0] RESET_PC   = SIZE'(DEFAULT_RESET_PC)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_step_mode,
  input  logic                  i_step,
  input  logic                  i_stall,
  input  logic                  i_halt,
  input  logic [SIZE-1:0]       i_next_pc,
  output logic [SIZE-1:0]       o_pc,
  output logic [SIZE-1:0]       o_pc_plus4,
  output logic                  o_advance,
  output logic                  o_halted,
  output logic [COUNT_SIZE-1:0] o_cycle_count
);

  pc_state_t             r_state;
  logic [SIZE-1:0]       r_pc;
  logic                  r_advance;
  logic                  r_halted;
  logic [COUNT_SIZE-1:0] r_count;

  logic                  w_step_rise;
  logic                  w_exec;
  logic [SIZE-1:0]       w_next_pc_aligned;

  pc_unit_edge_detect u_step_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_in    (i_step),
    .o_rise  (w_step_rise)
  );

  // Fetch addresses are word aligned; the mux may hand us unaligned targets.
  assign w_next_pc_aligned = i_next_pc & ~SIZE'(2'b11);

  assign w_exec = i_enable &&
                  ((r_state == RUN) || ((r_state == STEP_WAIT) && w_step_rise));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_advance <= 1'b0;
      r_halted  <= 1'b0;
      r_count   <= '0;
    end else begin
      r_advance <= 1'b0;

      case (r_state)
        IDLE:           if (i_enable)  r_state <= i_step_mode ? STEP_WAIT : RUN;
        RUN, STEP_WAIT: if (!i_enable) r_state <= IDLE;
        default:        ;
      endcase

      // Halt and stall cycles still count as executed; halt wins over stall.
      if (w_exec) begin
        if (r_count != '1) r_count <= r_count + COUNT_SIZE'(1);
        if (i_halt) begin
          r_state  <= HALTED;
          r_halted <= 1'b1;
        end else if (!i_stall) begin
          r_pc      <= w_next_pc_aligned;
          r_advance <= 1'b1;
        end
      end
    end
  end

  assign o_pc          = r_pc;
  assign o_pc_plus4    = r_pc + SIZE'(PC_INCREMENT);
  assign o_advance     = r_advance;
  assign o_halted      = r_halted;
  assign o_cycle_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// ----------------------------------------------------------------------------
// Module : tb_pc_unit
// Brief  : Self-checking bench for pc_unit; expected outputs queued per cycle.
// Rev    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pc_unit;

  localparam int SIZE       = 32;
  localparam int COUNT_SIZE = 4;

  typedef struct {
    string                 tag;
    logic [SIZE-1:0]       pc;
    logic                  adv;
    logic                  halted;
    logic [COUNT_SIZE-1:0] cnt;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst, en, mode, stp, stall, halt;
  logic [SIZE-1:0]       npc;
  logic [SIZE-1:0]       pc, pc_plus4;
  logic                  adv, halted;
  logic [COUNT_SIZE-1:0] cnt;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pc_unit #(
    .SIZE       (SIZE),
    .COUNT_SIZE (COUNT_SIZE),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_enable      (en),
    .i_step_mode   (mode),
    .i_step        (stp),
    .i_stall       (stall),
    .i_halt        (halt),
    .i_next_pc     (npc),
    .o_pc          (pc),
    .o_pc_plus4    (pc_plus4),
    .o_advance     (adv),
    .o_halted      (halted),
    .o_cycle_count (cnt)
  );

  task automatic check_eq(input string tag, input logic [SIZE-1:0] got, input logic [SIZE-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the edge.
  task automatic drive(input logic r, e, m, s, st, h, input logic [SIZE-1:0] n,
                       input string tag, input logic [SIZE-1:0] epc, input logic eadv,
                       input logic ehalt, input logic [COUNT_SIZE-1:0] ecnt);
    exp_t x;
    rst = r; en = e; mode = m; stp = s; stall = st; halt = h; npc = n;
    x.tag = tag; x.pc = epc; x.adv = eadv; x.halted = ehalt; x.cnt = ecnt;
    sb.push_back(x);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      exp_t x;
      x = sb.pop_front();
      check_eq({x.tag, ".pc"},     pc,                   x.pc);
      check_eq({x.tag, ".plus4"},  pc_plus4,             x.pc + 32'd4);
      check_eq({x.tag, ".adv"},    SIZE'(adv),           SIZE'(x.adv));
      check_eq({x.tag, ".halted"}, SIZE'(halted),        SIZE'(x.halted));
      check_eq({x.tag, ".count"},  SIZE'(cnt),           SIZE'(x.cnt));
    end
  end

  initial begin
    //     rst en md st sl ht next_pc        tag        exp_pc        adv hlt cnt
    drive(1, 0, 0, 0, 0, 0, 32'h0,          "reset",   32'h0,         0, 0, 4'd0);
    drive(0, 1, 0, 0, 0, 0, 32'h4,          "to_run",  32'h0,         0, 0, 4'd0);
    for (int i = 1; i <= 5; i++)
      drive(0, 1, 0, 0, 0, 0, 32'(4*i),     "run_seq", 32'(4*i),      1, 0, 4'(i));
    drive(0, 1, 0, 0, 1, 0, 32'h40,         "stall1",  32'd20,        0, 0, 4'd6);
    drive(0, 1, 0, 0, 1, 0, 32'h40,         "stall2",  32'd20,        0, 0, 4'd7);
    drive(0, 1, 0, 0, 0, 0, 32'h40,         "unstall", 32'h40,        1, 0, 4'd8);
    drive(0, 1, 0, 0, 0, 0, 32'h13,         "align",   32'h10,        1, 0, 4'd9);
    drive(1, 1, 0, 0, 0, 0, 32'h50,         "rst_run", 32'h0,         0, 0, 4'd0);
    drive(0, 1, 1, 0, 0, 0, 32'h100,        "to_step", 32'h0,         0, 0, 4'd0);
    drive(0, 1, 1, 1, 0, 0, 32'h100,        "step_a",  32'h100,       1, 0, 4'd1);
    for (int i = 0; i < 3; i++)
      drive(0, 1, 1, 1, 0, 0, 32'h100,      "step_hld",32'h100,       0, 0, 4'd1);
    drive(0, 1, 1, 0, 0, 0, 32'h200,        "step_lo", 32'h100,       0, 0, 4'd1);
    drive(0, 1, 1, 1, 0, 0, 32'h200,        "step_b",  32'h200,       1, 0, 4'd2);
    drive(0, 1, 1, 0, 0, 0, 32'h300,        "step_lo2",32'h200,       0, 0, 4'd2);
    drive(0, 1, 0, 0, 0, 0, 32'h300,        "mode_ign",32'h200,       0, 0, 4'd2);
    drive(0, 1, 0, 1, 1, 1, 32'h80,         "halt",    32'h200,       0, 1, 4'd3);
    drive(0, 1, 0, 0, 0, 0, 32'h84,         "hlt_lo",  32'h200,       0, 1, 4'd3);
    drive(0, 1, 1, 1, 0, 0, 32'h84,         "hlt_stp", 32'h200,       0, 1, 4'd3);
    drive(0, 0, 0, 0, 0, 0, 32'h88,         "hlt_dis", 32'h200,       0, 1, 4'd3);
    drive(0, 1, 0, 0, 0, 0, 32'h88,         "hlt_en",  32'h200,       0, 1, 4'd3);
    drive(1, 1, 0, 0, 0, 0, 32'h88,         "rst_hlt", 32'h0,         0, 0, 4'd0);
    drive(0, 0, 0, 0, 0, 0, 32'h88,         "idle",    32'h0,         0, 0, 4'd0);
    drive(0, 1, 0, 0, 0, 0, 32'hFFFF_FFFC,  "to_run2", 32'h0,         0, 0, 4'd0);
    drive(0, 1, 0, 0, 0, 0, 32'hFFFF_FFFC,  "wrap",    32'hFFFF_FFFC, 1, 0, 4'd1);
    drive(0, 1, 0, 0, 0, 0, 32'hFFFF_FFFF,  "wrap_al", 32'hFFFF_FFFC, 1, 0, 4'd2);
    for (int i = 3; i < 20; i++)
      drive(0, 1, 0, 0, 1, 0, 32'h0,        "satur",   32'hFFFF_FFFC, 0, 0, (i > 15) ? 4'd15 : 4'(i));
    drive(0, 0, 0, 0, 0, 0, 32'h0,          "dis",     32'hFFFF_FFFC, 0, 0, 4'd15);
    @(posedge clk);
    #2;
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
